imem_bank_pipelined: RTL
========================

Name: imem_bank_pipelined

Overview:
- Parametrised next-generation instruction memory for the MIPS-style core.
- Synchronous-read storage with a configurable read latency (1 or 2 cycles) and a fetch req/ready/valid handshake.
- Runtime program-load write port, so programs are loaded by the bench or boot logic instead of being hardcoded.
- Self-initialising: after reset, every word is cleared to a NOP before fetches are accepted.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 16, width of the fetch and load address ports.
- DEPTH, 256, number of words implemented; legal addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- READ_LAT, 1, fetch latency in cycles; legal values are 1 and 2.
- NOP_WORD, 16'h1000, fill value (addi $0,$0,0), also returned for out-of-range fetches.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- fetch_req, in, 1, fetch request.
- fetch_addr, in, ADDR_W, word address to fetch.
- fetch_ready, out, 1, high when a request is accepted this cycle.
- rd_valid, out, 1, read data valid.
- rd_data, out, DATA_W, fetched instruction.
- rd_oor, out, 1, with rd_valid: the fetched address was >= DEPTH.
- load_en, in, 1, program-load write strobe.
- load_addr, in, ADDR_W, load word address.
- load_data, in, DATA_W, load word.
- load_err, out, 1, one-cycle pulse: load was rejected (out of range, or issued during INIT).
- init_done, out, 1, high once the fill sequence has finished.

Behaviour:
- Reset (rst=1 at an edge):
  - Enter INIT with the fill counter at 0.
  - fetch_ready=0, rd_valid=0, rd_data=NOP_WORD, rd_oor=0, load_err=0, init_done=0.
  - The read pipeline is flushed. Reset mid-fill or mid-fetch restarts the fill from 0.
- State INIT:
  - Each cycle, write NOP_WORD to mem[fill_cnt], then increment fill_cnt.
  - After writing DEPTH-1, go to RUN the next cycle, so INIT lasts exactly DEPTH cycles.
  - load_en during INIT is ignored and load_err pulses the next cycle. fetch_ready=0.
- State RUN:
  - init_done=1.
  - fetch_ready = !load_en, so a load has priority and stalls fetch for that cycle.
  - A fetch is accepted when fetch_req && fetch_ready.
- Load in RUN:
  - If load_addr < DEPTH, mem[load_addr] <= load_data at the edge.
  - Otherwise nothing is written and load_err pulses the next cycle.
- Fetch latency:
  - READ_LAT=1: an accept at edge N gives rd_valid=1 and data after edge N+1.
  - READ_LAT=2: one extra output register stage, so data after edge N+2.
  - Back-to-back fetches are accepted every cycle at full throughput. There is no output backpressure.
- rd_valid is 0 on cycles with no accept in flight. rd_data holds its last value when rd_valid=0.
- Out-of-range fetch (fetch_addr >= DEPTH): rd_data=NOP_WORD and rd_oor=1, at the same latency as a normal fetch.
- Read-after-write: a fetch of an address loaded in an earlier cycle returns the new data. A same-cycle conflict cannot occur, because fetch is stalled while load_en is high.
- Address arithmetic is unsigned. There is no wrap-around; out-of-range is flagged instead.
- fill_cnt is ceil(log2(DEPTH)) bits wide and must not overflow when DEPTH is a power of two. The terminal comparison is against DEPTH-1.
- Illegal READ_LAT values are rejected at elaboration (generate-time error).

Decomposition:
- Shared package imem_pkg holds:
  - the state enum {INIT, RUN};
  - the default NOP_WORD constant;
  - opcode constants (ADDI=4'b0001, etc.) for bench program assembly.
- One natural sub-module, imem_rd_pipe: a parametrised READ_LAT-stage valid/data/oor delay line. The storage array and FSM stay in the top module.

Test Plan:
- Reset with DEPTH=256, then fetch addr 5 → init_done rises exactly 256 cycles after reset is released; rd_data=16'h1000, rd_valid 1 cycle after accept (READ_LAT=1).
- Load mem[3]=16'h1C05, then fetch 3 on the next cycle → rd_data=16'h1C05, rd_oor=0.
- Hold load_en=1 with fetch_req=1 → fetch_ready=0 for those cycles; the fetch is accepted on the first cycle after load_en drops.
- With READ_LAT=2, fetch addrs 0,1,2 back-to-back → rd_valid high for 3 consecutive cycles starting 2 cycles after the first accept, data in order.
- Fetch addr 300 (DEPTH=256) → rd_data=16'h1000, rd_oor=1. Load addr 300 → load_err pulses one cycle and memory is unchanged.
- Assert rst at fill_cnt=100, then release → INIT restarts and init_done rises 256 cycles after release; a load issued during INIT gives load_err=1 and is not written.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory bank: FSM states, the NOP
// fill word and opcode constants used when assembling test programs.
package imem_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } imem_state_e;

   // addi $0,$0,0 -- harmless filler and the out-of-range fetch result.
   localparam logic [15:0] IMEM_NOP = 16'h1000;

   // 16-bit instruction layout: op[15:12] rs[11:9] rt[8:6] imm[5:0].
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_LW   = 4'b0010;
   localparam logic [3:0] OP_SW   = 4'b0011;
   localparam logic [3:0] OP_BEQ  = 4'b0100;
   localparam logic [3:0] OP_J    = 4'b0101;

   function automatic logic [15:0] asm_i(input logic [3:0] op,
                                         input logic [2:0] rs,
                                         input logic [2:0] rt,
                                         input logic [5:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// LAT-stage valid/data/oor delay line for fetch results. Data stages only
// load on a valid beat, so the last stage holds its value between fetches.
module imem_rd_pipe #(
   parameter int                DATA_W   = 16,
   parameter int                LAT      = 1,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_oor,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_oor
);

   logic              valid_q [LAT];
   logic [DATA_W-1:0] data_q  [LAT];
   logic              oor_q   [LAT];

   // Shift the fetch beat through LAT register stages; reset flushes all stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= RST_DATA;
            oor_q[i]   <= 1'b0;
         end
      end else begin
         // NOTE: registers are assigned with <= so every stage samples the
         // pre-edge value of its predecessor regardless of statement order.
         valid_q[0] <= in_valid;
         oor_q[0]   <= in_valid && in_oor;
         if (in_valid) data_q[0] <= in_data;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            oor_q[i]   <= oor_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_data  = data_q[LAT-1];
   assign out_oor   = oor_q[LAT-1];

endmodule

// File: rtl/imem_bank_pipelined.sv
// Instruction memory bank: self-clearing storage (INIT fill), runtime program
// load port and a fetch path with 1- or 2-cycle registered read latency.
module imem_bank_pipelined
   import imem_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 256,
   parameter int                READ_LAT = 1,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_oor,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_err,
   output logic              init_done
);

   localparam int                FILL_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

   generate
      if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
         $error("imem_bank_pipelined: READ_LAT must be 1 or 2");
      end
   endgenerate

   imem_state_e       state, state_next;
   logic [FILL_W-1:0] fill_cnt, fill_next;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              load_in_range, fetch_in_range, accept;
   logic              mem_we, load_err_next;
   logic [FILL_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_data, rd_word;

   // Widen by one bit so DEPTH == 2**ADDR_W still compares correctly.
   assign load_in_range  = {1'b0, load_addr}  < DEPTH_X;
   assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;

   // Next-state, fill counter and the single memory write port (fill or load).
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a signal unassigned and infer a latch.
      state_next    = state;
      fill_next     = fill_cnt;
      fetch_ready   = 1'b0;
      init_done     = 1'b0;
      mem_we        = 1'b0;
      wr_idx        = fill_cnt;
      wr_data       = NOP_WORD;
      load_err_next = 1'b0;
      case (state)
         INIT: begin
            mem_we        = 1'b1;
            load_err_next = load_en;
            // Stop at DEPTH-1 rather than wrapping, so the counter never overflows.
            if (fill_cnt == FILL_LAST) state_next = RUN;
            else                       fill_next  = fill_cnt + FILL_W'(1);
         end
         RUN: begin
            init_done   = 1'b1;
            fetch_ready = !load_en;
            if (load_en) begin
               if (load_in_range) begin
                  mem_we  = 1'b1;
                  wr_idx  = load_addr[FILL_W-1:0];
                  wr_data = load_data;
               end else begin
                  load_err_next = 1'b1;
               end
            end
         end
         default: state_next = INIT;
      endcase
   end

   // State, fill counter and load error pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         fill_cnt <= '0;
         load_err <= 1'b0;
      end else begin
         state    <= state_next;
         fill_cnt <= fill_next;
         load_err <= load_err_next;
      end
   end

   // Storage write port.
   // NOTE: the array is deliberately not reset; the INIT fill clears it,
   // which keeps it mappable onto a RAM macro.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_idx] <= wr_data;
   end

   // Loads stall fetch, so a read never races a same-cycle write.
   assign accept  = fetch_req && fetch_ready;
   assign rd_word = fetch_in_range ? mem[fetch_addr[FILL_W-1:0]] : NOP_WORD;

   imem_rd_pipe #(
      .DATA_W   (DATA_W),
      .LAT      (READ_LAT),
      .RST_DATA (NOP_WORD)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_data   (rd_word),
      .in_oor    (!fetch_in_range),
      .out_valid (rd_valid),
      .out_data  (rd_data),
      .out_oor   (rd_oor)
   );

endmodule
